// File: rtl/fifo_status_logic_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_status_logic_if                                             |
// | Push/pop, threshold and status bundle for fifo_status_logic.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fifo_status_logic_if #(
    parameter int CNT_L = 3
);
    logic             push;
    logic             pop;
    logic             thr_load;
    logic [CNT_L-1:0] thr_hi_in;
    logic [CNT_L-1:0] thr_lo_in;
    logic             err_clr;
    logic [CNT_L-1:0] occupancy;
    logic             fifo_full;
    logic             fifo_empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow_err;
    logic             underflow_err;

    modport master (
        output push, pop, thr_load, thr_hi_in, thr_lo_in, err_clr,
        input  occupancy, fifo_full, fifo_empty, almost_full, almost_empty,
               overflow_err, underflow_err
    );

    modport slave (
        input  push, pop, thr_load, thr_hi_in, thr_lo_in, err_clr,
        output occupancy, fifo_full, fifo_empty, almost_full, almost_empty,
               overflow_err, underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/fifo_status_logic.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_status_logic                                                |
// | Occupancy counter with registered full/empty/threshold/error     |
// | status for a MEM_SIZE-entry FIFO.                                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fifo_status_logic #(
    parameter int MEM_SIZE = 4,
    parameter int CNT_L    = 3
) (
    input  wire                  clk,
    input  wire                  reset,
    fifo_status_logic_if.slave   bus
);

    localparam logic [CNT_L-1:0] c_MEM_SIZE   = CNT_L'(MEM_SIZE);
    localparam logic [CNT_L-1:0] c_THR_HI_RST = CNT_L'(MEM_SIZE - 1);
    localparam logic [CNT_L-1:0] c_THR_LO_RST = CNT_L'(1);
    localparam logic [CNT_L-1:0] c_ONE        = CNT_L'(1);

    logic [CNT_L-1:0] r_occ;
    logic [CNT_L-1:0] r_thr_hi;
    logic [CNT_L-1:0] r_thr_lo;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic [CNT_L-1:0] w_occ_next;
    logic [CNT_L-1:0] w_thr_hi_next;
    logic [CNT_L-1:0] w_thr_lo_next;
    logic             w_is_full;
    logic             w_is_empty;
    logic             w_ovf_evt;
    logic             w_udf_evt;

    assign w_is_full  = (r_occ == c_MEM_SIZE);
    assign w_is_empty = (r_occ == '0);
    assign w_ovf_evt  = bus.push & ~bus.pop & w_is_full;
    assign w_udf_evt  = bus.pop & w_is_empty;

    // Saturating count; push+pop at empty lands at 1 since only the write is real.
    always_comb begin
        w_occ_next = r_occ;
        case ({bus.push, bus.pop})
            2'b10:   if (!w_is_full)  w_occ_next = r_occ + c_ONE;
            2'b01:   if (!w_is_empty) w_occ_next = r_occ - c_ONE;
            2'b11:   if (w_is_empty)  w_occ_next = c_ONE;
            default: w_occ_next = r_occ;
        endcase
    end

    always_comb begin
        w_thr_hi_next = r_thr_hi;
        w_thr_lo_next = r_thr_lo;
        if (bus.thr_load) begin
            w_thr_hi_next = (bus.thr_hi_in > c_MEM_SIZE) ? c_MEM_SIZE : bus.thr_hi_in;
            w_thr_lo_next = (bus.thr_lo_in > c_MEM_SIZE) ? c_MEM_SIZE : bus.thr_lo_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ          <= '0;
            r_thr_hi       <= c_THR_HI_RST;
            r_thr_lo       <= c_THR_LO_RST;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_occ          <= w_occ_next;
            r_thr_hi       <= w_thr_hi_next;
            r_thr_lo       <= w_thr_lo_next;
            r_full         <= (w_occ_next == c_MEM_SIZE);
            r_empty        <= (w_occ_next == '0);
            r_almost_full  <= (w_occ_next >= w_thr_hi_next);
            r_almost_empty <= (w_occ_next <= w_thr_lo_next);
            // A new error event outranks a simultaneous clear.
            r_overflow     <= w_ovf_evt | (r_overflow  & ~bus.err_clr);
            r_underflow    <= w_udf_evt | (r_underflow & ~bus.err_clr);
        end
    end

    assign bus.occupancy     = r_occ;
    assign bus.fifo_full     = r_full;
    assign bus.fifo_empty    = r_empty;
    assign bus.almost_full   = r_almost_full;
    assign bus.almost_empty  = r_almost_empty;
    assign bus.overflow_err  = r_overflow;
    assign bus.underflow_err = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_status_logic.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_status_logic                                             |
// | Directed scenarios plus random traffic against a count model.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fifo_status_logic;

    localparam int MEM_SIZE = 4;
    localparam int CNT_L    = 3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    // Reference state: plain integers following the behavioural rules
    int m_occ;
    int m_hi;
    int m_lo;
    bit m_ovf;
    bit m_udf;

    fifo_status_logic_if #(.CNT_L(CNT_L)) bus ();

    fifo_status_logic #(
        .MEM_SIZE (MEM_SIZE),
        .CNT_L    (CNT_L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".occupancy"},     8'(bus.occupancy),     8'(m_occ));
        chk({tag, ".fifo_full"},     8'(bus.fifo_full),     8'(m_occ == MEM_SIZE));
        chk({tag, ".fifo_empty"},    8'(bus.fifo_empty),    8'(m_occ == 0));
        chk({tag, ".almost_full"},   8'(bus.almost_full),   8'(m_occ >= m_hi));
        chk({tag, ".almost_empty"},  8'(bus.almost_empty),  8'(m_occ <= m_lo));
        chk({tag, ".overflow_err"},  8'(bus.overflow_err),  8'(m_ovf));
        chk({tag, ".underflow_err"}, 8'(bus.underflow_err), 8'(m_udf));
    endtask

    task automatic model_reset();
        m_occ = 0;
        m_hi  = MEM_SIZE - 1;
        m_lo  = 1;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Sampling is #1 after the edge, so drives here never race the DUT.
    task automatic step(input string tag, input bit ph, input bit pp,
                        input bit tl, input int hi, input int lo, input bit ec);
        bit ovf_evt;
        bit udf_evt;
        bus.push      = ph;
        bus.pop       = pp;
        bus.thr_load  = tl;
        bus.thr_hi_in = CNT_L'(hi);
        bus.thr_lo_in = CNT_L'(lo);
        bus.err_clr   = ec;
        @(posedge clk);
        ovf_evt = ph && !pp && (m_occ == MEM_SIZE);
        udf_evt = pp && (m_occ == 0);
        if (ph && !pp)      m_occ = (m_occ < MEM_SIZE) ? m_occ + 1 : MEM_SIZE;
        else if (pp && !ph) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
        else if (ph && pp && m_occ == 0) m_occ = 1;
        if (tl) begin
            m_hi = (hi > MEM_SIZE) ? MEM_SIZE : hi;
            m_lo = (lo > MEM_SIZE) ? MEM_SIZE : lo;
        end
        m_ovf = ovf_evt || (m_ovf && !ec);
        m_udf = udf_evt || (m_udf && !ec);
        #1;
        check_all(tag);
    endtask

    // Pulse reset strictly between clock edges and check the immediate effect.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.thr_load = 1'b0;
        bus.thr_hi_in = '0; bus.thr_lo_in = '0; bus.err_clr = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset_edge");

        // Fill to full
        for (int i = 0; i < 4; i++) step("fill", 1, 0, 0, 0, 0, 0);
        // Pass-through at full, then genuine overflow
        for (int i = 0; i < 3; i++) step("passthru", 1, 1, 0, 0, 0, 0);
        step("overflow", 1, 0, 0, 0, 0, 0);

        // Drain, then underflow cases
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 0, 0, 0, 0);
        step("underflow", 0, 1, 0, 0, 0, 0);
        step("pushpop_empty", 1, 1, 0, 0, 0, 0);
        step("err_clr", 0, 0, 0, 0, 0, 1);

        // Threshold load with clamp
        step("to_two", 1, 0, 0, 0, 0, 0);
        step("thr_load", 0, 0, 1, 7, 2, 0);
        step("thr_push3", 1, 0, 0, 0, 0, 0);
        step("thr_push4", 1, 0, 0, 0, 0, 0);

        // Overflow coincident with clear keeps the flag
        step("clr_only", 0, 0, 0, 0, 0, 1);
        step("ovf_with_clr", 1, 0, 0, 0, 0, 1);
        step("low_clamp", 0, 1, 1, 2, 6, 0);

        // Asynchronous reset at occupancy 3
        step("pre_reset", 0, 0, 0, 0, 0, 0);
        async_reset("async_reset");
        step("post_reset", 1, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("random",
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 59) == 0) async_reset("random_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_status_logic.md
FIFO_STATUS_LOGIC -- requirements
Module: fifo_status_logic

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 4: number of FIFO entries.
REQ-002 SHALL have parameter CNT_L, default 3: occupancy width; SHALL be wide enough to hold MEM_SIZE.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port push  input  1  write accepted this cycle, from the write-pointer logic.
REQ-006 SHALL have port pop  input  1  read accepted this cycle, from the read-pointer logic.
REQ-007 SHALL have port thr_load  input  1  loads both threshold registers this cycle.
REQ-008 SHALL have port thr_hi_in  input  CNT_L  almost-full threshold value.
REQ-009 SHALL have port thr_lo_in  input  CNT_L  almost-empty threshold value.
REQ-010 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-011 SHALL have port occupancy  output  CNT_L  registered entry count.
REQ-012 SHALL have port fifo_full  output  1  occupancy == MEM_SIZE.
REQ-013 SHALL have port fifo_empty  output  1  occupancy == 0.
REQ-014 SHALL have port almost_full  output  1  occupancy >= threshold high.
REQ-015 SHALL have port almost_empty  output  1  occupancy <= threshold low.
REQ-016 SHALL have port overflow_err  output  1  sticky: push while full without pop.
REQ-017 SHALL have port underflow_err  output  1  sticky: pop while empty.

Function
REQ-018 SHALL update occupancy on each clk edge: push only -> +1; pop only -> -1; both or neither -> unchanged.
REQ-019 SHALL, on push with pop while full, keep occupancy at MEM_SIZE and not flag overflow; this is the pass-through case allowed by the write logic.
REQ-020 SHALL, on push without pop while full, hold occupancy at MEM_SIZE and set overflow_err.
REQ-021 SHALL, on pop while empty, ignore the pop and set underflow_err.
REQ-022 SHALL, on pop with push while empty, set occupancy to 1 and set underflow_err.
REQ-023 SHALL never let occupancy leave the range 0..MEM_SIZE; no wrap-around.
REQ-024 SHALL register every status output; each output reflects the occupancy after the edge, with 1-cycle latency from push/pop.
REQ-025 SHALL latch thr_hi_in and thr_lo_in into internal thresholds on a thr_load edge; otherwise the thresholds SHALL hold.
REQ-026 SHALL clamp a loaded thr_hi_in greater than MEM_SIZE to MEM_SIZE.
REQ-027 SHALL clamp a loaded thr_lo_in greater than MEM_SIZE to MEM_SIZE.
REQ-028 SHALL compute almost_full and almost_empty from the next occupancy and the next thresholds, so a threshold load takes effect on the same edge as the load.
REQ-029 SHALL clear both sticky errors on an err_clr edge; if an error condition coincides with err_clr, the flag SHALL end set (set wins).
REQ-030 SHALL treat overflow and underflow independently; both may be set in the same cycle only via separate events.

Reset
REQ-031 SHALL, while reset is high, asynchronously force occupancy=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, overflow_err=0, underflow_err=0.
REQ-032 SHALL, while reset is high, force threshold high to MEM_SIZE-1 and threshold low to 1.
REQ-033 SHALL, on reset asserted mid-operation, discard the count and thresholds immediately, without waiting for clk.
REQ-034 SHALL ignore push and pop on the first edge after reset deassertion only if reset is still high at that edge.

Verification
REQ-035 SHALL pass this scenario: reset, then 4 push cycles with MEM_SIZE=4 -> occupancy 1,2,3,4; almost_full rises at 3; fifo_full rises at 4; fifo_empty falls after the first push.
REQ-036 SHALL pass this scenario: at full, push+pop for 3 cycles -> occupancy stays 4, fifo_full stays 1, overflow_err stays 0; then push alone -> overflow_err=1, occupancy 4.
REQ-037 SHALL pass this scenario: from empty, pop -> underflow_err=1, occupancy 0; push+pop at empty -> occupancy 1, underflow_err=1; err_clr -> both errors 0 next cycle.
REQ-038 SHALL pass this scenario: thr_load with thr_hi_in=7, thr_lo_in=2 at occupancy 2 -> threshold high clamped to 4, almost_empty=1, almost_full=0; two pushes -> almost_empty=0 at 3, almost_full=1 at 4.
REQ-039 SHALL pass this scenario: reset pulsed high between edges at occupancy 3 -> outputs return to REQ-031 values immediately.
REQ-040 SHALL pass this scenario: err_clr coincident with push at full without pop -> overflow_err remains 1.
